// File: rtl/alu_operand_issue.sv
// alu_operand_issue
//   Issue stage feeding the ALU. Accepts RV32I instruction words on a
//   valid/ready handshake, decodes OP (0110011) and OP-IMM (0010011),
//   drives the register-file read addresses, captures the operands and
//   presents a registered ALU bundle. A main output register plus one
//   skid entry sustain full throughput under output backpressure.
//   Non-ALU opcodes are accepted and silently dropped.
//
// Ports
//   clk, rst (async, active-high), flush (sync, drops all entries)
//   in_valid/in_ready/in_instr          : instruction input handshake
//   rf_raddr1/rf_raddr2                 : combinational rs1/rs2 fields
//   rf_rdata1/rf_rdata2                 : same-cycle register-file data
//   out_valid/out_ready                 : ALU bundle handshake
//   out_src1, out_src2, out_imm_source, out_imm, out_funct3, out_funct7,
//   out_rd, out_illegal                 : registered ALU bundle
//
// Configuration macro
//   ALU_ISSUE_STRICT_EN : when defined, reject funct7 values outside the
//   base ISA (out_illegal=1, funct7 forced to 0). When undefined,
//   out_illegal is 0 and funct7 passes through unchecked.
module alu_operand_issue #(
  parameter int XLEN      = 32,  // only 32 supported
  parameter int RF_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  output logic [RF_ADDR_W-1:0] rf_raddr1,
  output logic [RF_ADDR_W-1:0] rf_raddr2,
  input  logic [XLEN-1:0]      rf_rdata1,
  input  logic [XLEN-1:0]      rf_rdata2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_src1,
  output logic [XLEN-1:0]      out_src2,
  output logic [XLEN-1:0]      out_imm_source,
  output logic                 out_imm,
  output logic [2:0]           out_funct3,
  output logic [6:0]           out_funct7,
  output logic [RF_ADDR_W-1:0] out_rd,
  output logic                 out_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef struct packed {
    logic [XLEN-1:0]      src1;
    logic [XLEN-1:0]      src2;
    logic [XLEN-1:0]      imm_source;
    logic                 imm;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic [RF_ADDR_W-1:0] rd;
    logic                 illegal;
  } bundle_t;

  bundle_t main_reg, skid_reg, dec;
  logic    main_valid_reg, skid_valid_reg;
  logic    is_alu;
  logic    take;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7_raw;
  logic       is_shift;

  assign opcode     = in_instr[6:0];
  assign funct3     = in_instr[14:12];
  assign funct7_raw = in_instr[31:25];
  assign is_shift   = (funct3 == 3'b001) || (funct3 == 3'b101);

  assign rf_raddr1 = in_instr[19:15];
  assign rf_raddr2 = in_instr[24:20];

  // Combinational decode of the incoming word into a bundle.
  always_comb begin
    dec        = '0;
    is_alu     = 1'b0;
    dec.src1   = rf_rdata1;
    dec.src2   = rf_rdata2;
    dec.funct3 = funct3;
    dec.rd     = in_instr[11:7];
    if (opcode == OPC_OP) begin
      is_alu     = 1'b1;
      dec.imm    = 1'b0;
      dec.funct7 = funct7_raw;
`ifdef ALU_ISSUE_STRICT_EN
      if (!(funct7_raw == 7'h00 ||
            (funct7_raw == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)))) begin
        dec.illegal = 1'b1;
        dec.funct7  = 7'h00;
      end
`endif
    end else if (opcode == OPC_OP_IMM) begin
      is_alu  = 1'b1;
      dec.imm = 1'b1;
      if (is_shift) begin
        dec.imm_source = {{(XLEN-5){1'b0}}, in_instr[24:20]};
        dec.funct7     = funct7_raw;
`ifdef ALU_ISSUE_STRICT_EN
        if (!(funct7_raw == 7'h00 || (funct7_raw == 7'h20 && funct3 == 3'b101))) begin
          dec.illegal = 1'b1;
          dec.funct7  = 7'h00;
        end
`endif
      end else begin
        dec.imm_source = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
        dec.funct7     = 7'h00;
      end
    end
  end

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready = !skid_valid_reg;
  assign take     = in_valid && in_ready && is_alu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_reg       <= '0;
      skid_reg       <= '0;
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (flush) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (!main_valid_reg || out_ready) begin
      // Main is free this cycle (empty or delivering). A full skid implies
      // in_ready was low, so no new word can be competing with it.
      if (skid_valid_reg) begin
        main_reg       <= skid_reg;
        main_valid_reg <= 1'b1;
        skid_valid_reg <= 1'b0;
      end else if (take) begin
        main_reg       <= dec;
        main_valid_reg <= 1'b1;
      end else begin
        main_valid_reg <= 1'b0;
      end
    end else if (take) begin
      // Main stalled: park the new word in the skid entry.
      skid_reg       <= dec;
      skid_valid_reg <= 1'b1;
    end
  end

  assign out_valid      = main_valid_reg;
  assign out_src1       = main_reg.src1;
  assign out_src2       = main_reg.src2;
  assign out_imm_source = main_reg.imm_source;
  assign out_imm        = main_reg.imm;
  assign out_funct3     = main_reg.funct3;
  assign out_funct7     = main_reg.funct7;
  assign out_rd         = main_reg.rd;
  assign out_illegal    = main_reg.illegal;

endmodule

// File: tb/tb_alu_operand_issue.sv
// tb_alu_operand_issue
//   Directed bench for alu_operand_issue with a scoreboard: an expected
//   bundle is queued whenever an ALU word is accepted and compared when the
//   DUT delivers. Also checks output hold under stall, reset, flush, and
//   the funct7 checking option (ALU_ISSUE_STRICT_EN).
module tb_alu_operand_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_src1, out_src2, out_imm_source;
  logic        out_imm;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rd;
  logic        out_illegal;

  alu_operand_issue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_src1(out_src1), .out_src2(out_src2), .out_imm_source(out_imm_source),
    .out_imm(out_imm), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_rd(out_rd), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] imm_source;
    logic        imm;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic        illegal;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   dcount = 0;
  exp_t sb[$];
  logic prev_stall = 1'b0;
  exp_t held;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm12, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] opc);
    return {imm12, rs1, f3, rd, opc};
  endfunction

  function automatic logic is_alu_word(input logic [31:0] w);
    return (w[6:0] == 7'b0110011) || (w[6:0] == 7'b0010011);
  endfunction

  // Reference decode of an accepted instruction.
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       legal;
    f3 = w[14:12];
    f7 = w[31:25];
    r = '0;
    r.src1 = a;
    r.src2 = b;
    r.funct3 = f3;
    r.rd = w[11:7];
    legal = 1'b1;
    if (w[6:0] == 7'b0110011) begin
      r.funct7 = f7;
      legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    end else begin
      r.imm = 1'b1;
      if (f3 == 3'd1 || f3 == 3'd5) begin
        r.imm_source = {27'd0, w[24:20]};
        r.funct7 = f7;
        legal = (f7 == 7'h00) || (f7 == 7'h20 && f3 == 3'd5);
      end else begin
        r.imm_source = {{20{w[31]}}, w[31:20]};
      end
    end
`ifdef ALU_ISSUE_STRICT_EN
    if (!legal) begin
      r.illegal = 1'b1;
      r.funct7 = 7'h00;
    end
`else
    legal = 1'b1;
    r.illegal = !legal;
`endif
    return r;
  endfunction

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t obs;
    exp_t e;
    obs = {out_src1, out_src2, out_imm_source, out_imm, out_funct3, out_funct7, out_rd, out_illegal};
    if (rst || flush) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {127'd0, out_valid}, 128'd1);
        chk("hold_data", {15'd0, obs}, {15'd0, held});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", {127'd0, out_valid}, 128'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_bundle", {15'd0, obs}, {15'd0, e});
        end
        dcount++;
        $display("deliver rd=%0d src1=%h src2=%h imm_source=%h imm=%0d f3=%0d f7=%h illegal=%0d",
                 out_rd, out_src1, out_src2, out_imm_source, out_imm, out_funct3, out_funct7, out_illegal);
      end
      if (in_valid && in_ready && is_alu_word(in_instr))
        sb.push_back(model(in_instr, rf_rdata1, rf_rdata2));
      prev_stall = out_valid && !out_ready;
      held = obs;
    end
  end

  // Present a word and hold it until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
    bit got;
    in_valid = 1'b1;
    in_instr = w;
    rf_rdata1 = a;
    rf_rdata2 = b;
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("send_timeout", {127'd0, in_ready}, 128'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  logic [31:0] stream [9];

  initial begin
    int t0;
    int d0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
    rf_rdata1 = '0; rf_rdata2 = '0; out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_data", {15'd0, out_src1, out_src2, out_imm_source, out_imm, out_funct3,
                     out_funct7, out_rd, out_illegal}, 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: add x3,x1,x2
    out_ready = 1'b1;
    send(r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'd5, 32'd7);
    idle();
    chk("t1_raddr", {118'd0, rf_raddr1, rf_raddr2}, {118'd0, 5'd1, 5'd2});
    @(negedge clk);
    chk("t1_valid", {127'd0, out_valid}, 128'd1);
    chk("t1_src", {64'd0, out_src1, out_src2}, {64'd0, 32'd5, 32'd7});
    chk("t1_ctl", {112'd0, out_imm, out_funct3, out_funct7, out_rd},
                  {112'd0, 1'b0, 3'd0, 7'd0, 5'd3});

    // 2: addi x1,x0,-1 then srai x2,x1,4
    @(posedge clk); #1;
    send(i_type(12'hFFF, 5'd0, 3'd0, 5'd1, 7'b0010011), 32'd0, 32'd0);
    idle();
    @(negedge clk);
    chk("t2_addi_imm", {96'd0, out_imm_source}, {96'd0, 32'hFFFF_FFFF});
    chk("t2_addi_f7", {121'd0, out_funct7}, 128'd0);
    @(posedge clk); #1;
    send({7'h20, 5'd4, 5'd1, 3'd5, 5'd2, 7'b0010011}, 32'hFFFF_FFFF, 32'd0);
    idle();
    @(negedge clk);
    chk("t2_srai", {86'd0, out_imm_source, out_funct7, out_funct3},
                   {86'd0, 32'd4, 7'h20, 3'd5});

    // 3: A,B,C with out_ready low
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(r_type(7'h00, 5'd4, 5'd5, 3'd4, 5'd10), 32'hA0, 32'hA1);
    send(r_type(7'h20, 5'd6, 5'd7, 3'd0, 5'd11), 32'hB0, 32'hB1);
    chk("t3_in_ready_low", {127'd0, in_ready}, 128'd0);
    in_instr = i_type(12'h123, 5'd8, 3'd6, 5'd12, 7'b0010011);
    rf_rdata1 = 32'hC0; rf_rdata2 = 32'hC1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(i_type(12'h123, 5'd8, 3'd6, 5'd12, 7'b0010011), 32'hC0, 32'hC1);
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("t3_drained", sb.size(), 128'd0);

    // 4: 8 ALU words with a lw in the middle, full rate
    stream[0] = r_type(7'h00, 5'd1, 5'd2, 3'd0, 5'd1);
    stream[1] = r_type(7'h20, 5'd3, 5'd4, 3'd0, 5'd2);
    stream[2] = i_type(12'h800, 5'd5, 3'd4, 5'd3, 7'b0010011);
    stream[3] = i_type(12'h01F, 5'd6, 3'd1, 5'd4, 7'b0010011);
    stream[4] = i_type(12'h004, 5'd1, 3'd2, 5'd5, 7'b0000011);
    stream[5] = r_type(7'h00, 5'd7, 5'd8, 3'd7, 5'd6);
    stream[6] = i_type(12'h7FF, 5'd9, 3'd3, 5'd7, 7'b0010011);
    stream[7] = r_type(7'h20, 5'd10, 5'd11, 3'd5, 5'd8);
    stream[8] = i_type(12'h405, 5'd12, 3'd5, 5'd9, 7'b0010011);
    t0 = cyc;
    d0 = dcount;
    for (int i = 0; i < 9; i++)
      send(stream[i], $urandom, $urandom);
    idle();
    chk("t4_rate", cyc - t0, 128'd9);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_count", dcount - d0, 128'd8);

    // 5: flush with main+skid full; flush with accept; async reset
    out_ready = 1'b0;
    send(r_type(7'h00, 5'd1, 5'd2, 3'd1, 5'd13), 32'h11, 32'h12);
    send(r_type(7'h00, 5'd3, 5'd4, 3'd2, 5'd14), 32'h13, 32'h14);
    idle();
    chk("t5_full", {126'd0, out_valid, in_ready}, {126'd0, 2'b10});
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("t5_flush", {126'd0, out_valid, in_ready}, {126'd0, 2'b01});
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_instr = r_type(7'h00, 5'd1, 5'd1, 3'd0, 5'd15);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    idle();
    chk("t5_flush_accept", {127'd0, out_valid}, 128'd0);
    out_ready = 1'b0;
    send(r_type(7'h00, 5'd1, 5'd2, 3'd0, 5'd16), 32'h21, 32'h22);
    send(r_type(7'h00, 5'd1, 5'd2, 3'd0, 5'd17), 32'h23, 32'h24);
    idle();
    #2 rst = 1'b1;
    #1;
    chk("t5_async_rst", {126'd0, out_valid, in_ready}, {126'd0, 2'b01});
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 6: OP with funct7=7'h01, plus a sub and a slli with funct7=7'h20
    out_ready = 1'b1;
    send(r_type(7'h01, 5'd2, 5'd1, 3'd0, 5'd7), 32'h31, 32'h32);
    idle();
    @(negedge clk);
`ifdef ALU_ISSUE_STRICT_EN
    chk("t6_strict", {120'd0, out_illegal, out_funct7}, {120'd0, 1'b1, 7'h00});
`else
    chk("t6_pass", {120'd0, out_illegal, out_funct7}, {120'd0, 1'b0, 7'h01});
`endif
    @(posedge clk); #1;
    send(r_type(7'h20, 5'd2, 5'd1, 3'd0, 5'd8), 32'h41, 32'h42);
    send({7'h20, 5'd3, 5'd1, 3'd1, 5'd9, 7'b0010011}, 32'h51, 32'h52);
    idle();

    // Drain
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    #1;
    chk("final_drain", sb.size(), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
